// File: rtl/layer_ram_controller_if.sv
// Handshake and RAM-port bundle for layer_ram_controller.
// slave is the controller side; master is the network controller plus RAMs.
interface layer_ram_controller_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic                 start;
  logic [1:0]           layer;
  logic                 done;
  logic                 busy;
  logic                 rd_en;
  logic [AW-1:0]        w_addr;
  logic [AW-1:0]        x_addr;
  logic signed [DW-1:0] w_data;
  logic signed [DW-1:0] x_data;
  logic                 y_we;
  logic [AW-1:0]        y_addr;
  logic signed [DW-1:0] y_data;

  modport slave (
    input  start, layer, w_data, x_data,
    output done, busy, rd_en, w_addr, x_addr, y_we, y_addr, y_data
  );

  modport master (
    output start, layer, w_data, x_data,
    input  done, busy, rd_en, w_addr, x_addr, y_we, y_addr, y_data
  );
endinterface

// File: rtl/layer_ram_controller.sv
// Sequences one fully-connected layer: reads N weights/activations per neuron,
// accumulates signed products, writes the scaled and saturated result back.
module layer_ram_controller #(
  parameter int DW   = 8,
  parameter int N    = 4,
  parameter int FRAC = 4,
  parameter int AW   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  layer_ram_controller_if.slave bus
);

  localparam int CW   = $clog2(N);
  localparam int ACCW = 2 * DW + CW;
  localparam logic [CW-1:0]          LAST    = CW'(N - 1);
  localparam logic signed [ACCW-1:0] YMAX    = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] YMIN    = ~YMAX;
  localparam logic signed [DW-1:0]   YMAX_DW = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0]   YMIN_DW = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              layer_q;
  logic [CW-1:0]           n;
  logic [CW-1:0]           i;
  logic signed [ACCW-1:0]  acc;
  logic signed [2*DW-1:0]  prod_raw;
  logic signed [ACCW-1:0]  prod;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    y_sat;

  logic                    done_c;
  logic                    rd_en_c;
  logic                    y_we_c;
  logic [AW-1:0]           w_addr_c;
  logic [AW-1:0]           x_addr_c;
  logic [AW-1:0]           y_addr_c;
  logic signed [DW-1:0]    y_data_c;

  always_comb begin
    prod_raw = (2 * DW)'(bus.w_data) * (2 * DW)'(bus.x_data);
    prod     = ACCW'(prod_raw);
    shifted  = acc >>> FRAC;
    if (shifted > YMAX)
      y_sat = YMAX_DW;
    else if (shifted < YMIN)
      y_sat = YMIN_DW;
    else
      y_sat = shifted[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Read data trails rd_en by one cycle: the first READ cycle of a neuron has
  // nothing to add yet, and DRAIN picks up the product of the last read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      layer_q <= '0;
      n       <= '0;
      i       <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.layer != 2'd3) begin
            layer_q <= bus.layer;
            n       <= '0;
            i       <= '0;
            acc     <= '0;
          end
        end
        READ: begin
          i <= i + 1'b1;
          if (i != '0)
            acc <= acc + prod;
        end
        DRAIN: acc <= acc + prod;
        WRITE: begin
          if (n != LAST) begin
            n   <= n + 1'b1;
            i   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    rd_en_c    = 1'b0;
    y_we_c     = 1'b0;
    w_addr_c   = '0;
    x_addr_c   = '0;
    y_addr_c   = '0;
    y_data_c   = '0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_next = (bus.layer == 2'd3) ? DONE : READ;
      end
      READ: begin
        rd_en_c  = 1'b1;
        w_addr_c = AW'(layer_q) * AW'(N * N) + AW'(n) * AW'(N) + AW'(i);
        x_addr_c = AW'(layer_q) * AW'(N) + AW'(i);
        if (i == LAST)
          state_next = DRAIN;
      end
      DRAIN: state_next = WRITE;
      WRITE: begin
        y_we_c     = 1'b1;
        y_addr_c   = (AW'(layer_q) + AW'(1)) * AW'(N) + AW'(n);
        y_data_c   = y_sat;
        state_next = (n == LAST) ? DONE : READ;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.done   = done_c;
  assign bus.busy   = (state != IDLE);
  assign bus.rd_en  = rd_en_c;
  assign bus.w_addr = w_addr_c;
  assign bus.x_addr = x_addr_c;
  assign bus.y_we   = y_we_c;
  assign bus.y_addr = y_addr_c;
  assign bus.y_data = y_data_c;

  strobe_exclusive: assert property (@(posedge clk) disable iff (!reset) !(rd_en_c && y_we_c));

endmodule

// File: tb/tb_layer_ram_controller.sv
// Directed bench: RAM models plus a cycle-indexed layer timeline model checked every cycle.
module tb_layer_ram_controller;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int FRAC = 4;
  localparam int AW   = 8;
  localparam int LLEN = N * (N + 2) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_ram_controller_if #(.DW(DW), .AW(AW)) bus ();

  layer_ram_controller #(.DW(DW), .N(N), .FRAC(FRAC), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [DW-1:0] wmem [256];
  logic signed [DW-1:0] xmem [256];
  logic signed [DW-1:0] ymem [256];

  int errors = 0;
  int checks = 0;
  int rd_count = 0;
  int wr_count = 0;
  int rd_mark = 0;
  int first_w = -1;
  int c = 0;
  int m_layer = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_y(input int l, input int nn);
    int s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += int'(wmem[l * N * N + nn * N + k]) * int'(xmem[l * N + k]);
    s = s >>> FRAC;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // RAMs: data valid one cycle after rd_en, junk otherwise
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.w_data <= wmem[bus.w_addr];
      bus.x_data <= xmem[bus.x_addr];
      rd_count   <= rd_count + 1;
      if (rd_count == rd_mark)
        first_w <= int'(bus.w_addr);
    end else begin
      bus.w_data <= 8'sd99;
      bus.x_data <= -8'sd77;
    end
    if (bus.y_we) begin
      ymem[bus.y_addr] <= bus.y_data;
      wr_count         <= wr_count + 1;
    end
  end

  // Timeline model: c = cycles since the accepting edge, 0 when idle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      c <= 0;
    end else begin
      cyc <= cyc + 1;
      if (c == 0) begin
        if (bus.start) begin
          c         <= 1;
          m_layer   <= int'(bus.layer);
          start_cyc <= cyc + 1;
        end
      end else if (c >= ((m_layer == 3) ? 1 : LLEN)) begin
        c <= 0;
      end else begin
        c <= c + 1;
      end
    end
  end

  always @(negedge clk) begin
    int nn, p;
    logic e_rd, e_we, e_done;
    if (!reset) begin
      chk("rst_done", int'(bus.done), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rd_en", int'(bus.rd_en), 0);
      chk("rst_y_we", int'(bus.y_we), 0);
      chk("rst_w_addr", int'(bus.w_addr), 0);
      chk("rst_x_addr", int'(bus.x_addr), 0);
      chk("rst_y_addr", int'(bus.y_addr), 0);
      chk("rst_y_data", int'(bus.y_data), 0);
    end else if (c == 0) begin
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
      chk("idle_rd_en", int'(bus.rd_en), 0);
      chk("idle_y_we", int'(bus.y_we), 0);
    end else begin
      nn = (c - 1) / (N + 2);
      p  = (c - 1) % (N + 2);
      if (m_layer == 3) begin
        e_done = (c == 1);
        e_rd   = 1'b0;
        e_we   = 1'b0;
      end else begin
        e_done = (c == LLEN);
        e_rd   = !e_done && (p < N);
        e_we   = !e_done && (p == N + 1);
      end
      chk("busy", int'(bus.busy), 1);
      chk("done", int'(bus.done), int'(e_done));
      chk("rd_en", int'(bus.rd_en), int'(e_rd));
      chk("y_we", int'(bus.y_we), int'(e_we));
      if (e_rd && bus.rd_en) begin
        chk("w_addr", int'(bus.w_addr), m_layer * N * N + nn * N + p);
        chk("x_addr", int'(bus.x_addr), m_layer * N + p);
      end
      if (e_we && bus.y_we) begin
        chk("y_addr", int'(bus.y_addr), (m_layer + 1) * N + nn);
        chk("y_data", int'(bus.y_data), exp_y(m_layer, nn));
      end
      if (bus.done)
        done_cyc <= cyc;
    end
  end

  task automatic pulse_start(input logic [1:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int k;
    k = 0;
    while (k < 100) begin
      if (bus.done) break;
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("done_timeout", 0, 1);
    @(negedge clk);
    lat = done_cyc - start_cyc + 1;
  endtask

  task automatic fill_w(input int v);
    for (int k = 0; k < 256; k++) wmem[k] = DW'(v);
  endtask

  initial begin
    int lat, wb, k;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.layer = 2'd0;
    for (int a = 0; a < 256; a++) xmem[a] = '0;
    fill_w(16);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // basic layer 0: weights 16, x = 1..4 -> each neuron 160>>4 = 10
    for (int a = 0; a < 4; a++) xmem[a] = DW'(a + 1);
    wb = wr_count;
    pulse_start(2'd0);
    wait_done(lat);
    chk("l0_latency", lat, 25);
    chk("l0_writes", wr_count - wb, 4);
    for (int a = 4; a < 8; a++) chk("l0_y", int'(ymem[a]), 10);

    // layer 2 addressing: x = -1..-4 -> -160>>>4 = -10
    for (int a = 0; a < 4; a++) xmem[8 + a] = DW'(-(a + 1));
    rd_mark = rd_count;
    pulse_start(2'd2);
    wait_done(lat);
    chk("l2_first_w", first_w, 32);
    for (int a = 12; a < 16; a++) chk("l2_y", int'(ymem[a]), -10);

    // saturation high and low on layer 1
    fill_w(127);
    for (int a = 4; a < 8; a++) xmem[a] = 8'sd127;
    pulse_start(2'd1);
    wait_done(lat);
    for (int a = 8; a < 12; a++) chk("sat_hi_y", int'(ymem[a]), 127);
    fill_w(-128);
    pulse_start(2'd1);
    wait_done(lat);
    for (int a = 8; a < 12; a++) chk("sat_lo_y", int'(ymem[a]), -128);

    // distinct weights per neuron/input: neuron 0 = -24+35-42-10 = -41 -> -3; neuron 3 = 43 -> 2
    for (int a = 0; a < 16; a++) wmem[16 + a] = DW'(a - 8);
    xmem[4] = 8'sd3; xmem[5] = -8'sd5; xmem[6] = 8'sd7; xmem[7] = 8'sd2;
    pulse_start(2'd1);
    wait_done(lat);
    chk("mix_y0", int'(ymem[8]), -3);
    chk("mix_y3", int'(ymem[11]), 2);

    // layer 3: immediate done, no RAM traffic
    wb = wr_count;
    rd_mark = rd_count;
    pulse_start(2'd3);
    wait_done(lat);
    chk("l3_latency", lat, 1);
    chk("l3_reads", rd_count - rd_mark, 0);
    chk("l3_writes", wr_count - wb, 0);

    // start re-pulsed during neuron 1 READ is ignored: x = 4 -> 256>>4 = 16
    fill_w(16);
    for (int a = 0; a < 4; a++) xmem[a] = 8'sd4;
    wb = wr_count;
    pulse_start(2'd0);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    bus.layer = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("repulse_latency", lat, 25);
    chk("repulse_writes", wr_count - wb, 4);
    for (int a = 4; a < 8; a++) chk("repulse_y", int'(ymem[a]), 16);

    // reset during WRITE of neuron 2, then a clean rerun: x = 3 -> 192>>4 = 12
    for (int a = 0; a < 4; a++) xmem[a] = 8'sd2;
    wb = wr_count;
    pulse_start(2'd0);
    k = 0;
    while (c != 18 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_write2", c, 18);
    chk("write2_we", int'(bus.y_we), 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_y_we", int'(bus.y_we), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_y_data", int'(bus.y_data), 0);
    chk("abort_y_addr", int'(bus.y_addr), 0);
    chk("abort_writes", wr_count - wb, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) xmem[a] = 8'sd3;
    wb = wr_count;
    pulse_start(2'd0);
    wait_done(lat);
    chk("rerun_latency", lat, 25);
    chk("rerun_writes", wr_count - wb, 4);
    for (int a = 4; a < 8; a++) chk("rerun_y", int'(ymem[a]), 12);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_ram_controller.md
LAYER_RAM_CONTROLLER -- requirements
Module: layer_ram_controller

Interface
REQ-001 Parameters SHALL be: DW, default 8, signed data/weight width; N, default 4, neurons per layer and inputs per neuron (power of 2, >=2); FRAC, default 4, fixed-point fraction bits; AW, default 8, RAM address width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle layer-start pulse from the network controller.
REQ-005 layer  input  2  layer index; sampled only when start is accepted.
REQ-006 done  output  1  one-cycle pulse; layer complete.
REQ-007 busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-008 rd_en  output  1  read strobe for the weight and activation RAMs.
REQ-009 w_addr  output  AW  weight RAM address.
REQ-010 x_addr  output  AW  activation RAM read address.
REQ-011 w_data, x_data  input  DW each  signed read data, valid exactly one cycle after rd_en.
REQ-012 y_we  output  1  activation RAM write strobe.
REQ-013 y_addr  output  AW  activation RAM write address.
REQ-014 y_data  output  DW  signed neuron result.

Function
REQ-015 States SHALL be IDLE, READ, DRAIN, WRITE, DONE; counters n (neuron) and i (input), each 0..N-1.
REQ-016 IDLE: start=1 with layer<=2 -> latch layer, clear n, i, accumulator; go to READ.
REQ-017 IDLE: start=1 with layer=3 -> go to DONE with no RAM read or write.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 READ: rd_en=1 for N consecutive cycles; w_addr=layer*N*N+n*N+i; x_addr=layer*N+i; i increments per cycle; after i=N-1 go to DRAIN.
REQ-020 Each cycle following an rd_en cycle: acc += w_data*x_data (signed full-precision product); acc width = 2*DW+log2(N), which cannot overflow.
REQ-021 DRAIN: add final product; rd_en=0; go to WRITE.
REQ-022 WRITE: y_we=1 for exactly one cycle; y_addr=(layer+1)*N+n; y_data = acc arithmetic-shifted right by FRAC, saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 WRITE exit: n<N-1 -> n+1, i=0, acc=0, go to READ; n=N-1 -> go to DONE.
REQ-024 DONE: done=1 for one cycle; next state IDLE.
REQ-025 Latency: start accepted at edge E -> done high in cycle E+N*(N+2)+1; for N=4, 24 busy cycles, then the done cycle.
REQ-026 rd_en and y_we SHALL never be high in the same cycle; address outputs are don't-care when their strobe is low.
REQ-027 Address arithmetic SHALL be computed at AW bits; the instantiating level guarantees 3*N*N <= 2^AW.

Reset
REQ-028 reset low SHALL immediately force state IDLE and set done=0, busy=0, rd_en=0, y_we=0, w_addr=0, x_addr=0, y_addr=0, y_data=0, n=0, i=0, acc=0; this applies at any time, including mid-layer.
REQ-029 After reset deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Verification
REQ-030 N=4, DW=8, FRAC=4; all weights 16; x[0..3]=1,2,3,4; start, layer=0 -> y_we at y_addr 4,5,6,7, each y_data=10; done in cycle 25 after the start edge.
REQ-031 All weights 127, inputs 127 -> y_data=127 (saturated); all weights -128, inputs 127 -> y_data=-128.
REQ-032 layer=2 -> w_addr starts at 32; x_addr 8..11; y_addr 12..15.
REQ-033 layer=3 -> done in the cycle after the start edge; no rd_en or y_we activity.
REQ-034 start re-pulsed during READ of neuron 1 -> ignored; done timing and all writes unchanged.
REQ-035 reset asserted during WRITE of neuron 2 -> all outputs 0 the same cycle, no further y_we; a new start after release runs a full layer from neuron 0.
